// File: rtl/burst_ram_responder.sv
// burst_ram_responder: PSRAM-HS-timed 4-beat burst RAM endpoint backed by a 64-bit array
// Ports: clk/rst_n (async active-low); br_cmd (0 rd, 1 wr), br_cmd_en (pulse), br_addr (byte addr),
// br_wr_data/br_data_mask (per-beat write data, mask 1 = lane kept); br_rd_data/br_rd_data_valid (read beats);
// init_calib (commands accepted only when high); cmd_error (sticky rejected-command flag)
module burst_ram_responder #(
  parameter int AddressBitWidth       = 21,
  parameter int DepthBitWidth         = 10,
  parameter int ReadLatencyCycles     = 12,
  parameter int CommandIntervalCycles = 14,
  parameter int CalibrationCycles     = 100
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       br_cmd,
  input  logic                       br_cmd_en,
  input  logic [AddressBitWidth-1:0] br_addr,
  input  logic [63:0]                br_wr_data,
  input  logic [7:0]                 br_data_mask,
  output logic [63:0]                br_rd_data,
  output logic                       br_rd_data_valid,
  output logic                       init_calib,
  output logic                       cmd_error
);
  typedef enum logic [1:0] {IDLE, WRITE, RWAIT, RBURST} state_t;
  localparam logic [4:0] LatInit = 5'(ReadLatencyCycles - 1);
  localparam logic [5:0] IvlInit = 6'(CommandIntervalCycles - 1);
  localparam logic [9:0] CalLast = 10'(CalibrationCycles == 0 ? 0 : CalibrationCycles - 1);
  state_t r_state, w_next;
  logic [63:0] r_mem [2**DepthBitWidth];
  logic [DepthBitWidth-1:0] r_idx, w_idx, w_addr;
  logic [1:0] r_beat;
  logic [4:0] r_lat;
  logic [5:0] r_ivl;
  logic [9:0] r_cal;
  logic w_accept, w_we, w_rd, w_unused;
  assign w_idx    = br_addr[DepthBitWidth+2:3];
  assign w_unused = ^{br_addr[2:0], br_addr >> (DepthBitWidth + 3)};
  assign w_accept = br_cmd_en && init_calib && r_state == IDLE && r_ivl == '0;
  // beat 0 of a write is stored on the accept edge itself, so Idle addresses straight from br_addr
  assign w_addr   = (r_state == IDLE) ? w_idx : r_idx + DepthBitWidth'(r_beat);
  assign w_we     = (r_state == IDLE) ? w_accept && br_cmd : r_state == WRITE;
  // r_beat wraps to 0 after beat 3, which marks the trailing ReadBurst cycle with valid low
  assign w_rd     = (r_state == RWAIT && r_lat == '0) || (r_state == RBURST && r_beat != '0);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? (br_cmd ? WRITE : RWAIT) : IDLE;
      WRITE:   w_next = (r_beat == 2'd3) ? IDLE : WRITE;
      RWAIT:   w_next = (r_lat == '0) ? RBURST : RWAIT;
      RBURST:  w_next = (r_beat == '0) ? IDLE : RBURST;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_rd_data       <= '0;
      br_rd_data_valid <= 1'b0;
      init_calib       <= 1'b0;
      cmd_error        <= 1'b0;
      r_cal            <= '0;
      r_ivl            <= '0;
      r_lat            <= '0;
      r_idx            <= '0;
      r_beat           <= '0;
    end else begin
      init_calib       <= init_calib || r_cal == CalLast;
      r_cal            <= init_calib ? r_cal : r_cal + 1'b1;
      cmd_error        <= cmd_error || (br_cmd_en && !w_accept);
      r_ivl            <= w_accept ? IvlInit : (r_ivl != '0 ? r_ivl - 1'b1 : r_ivl);
      r_lat            <= w_accept ? LatInit : (r_state == RWAIT && r_lat != '0 ? r_lat - 1'b1 : r_lat);
      r_idx            <= w_accept ? w_idx : r_idx;
      r_beat           <= (w_we || w_rd) ? r_beat + 1'b1 : r_beat;
      br_rd_data_valid <= w_rd;
      br_rd_data       <= w_rd ? r_mem[w_addr] : br_rd_data;
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < 8; i++)
      if (w_we && !br_data_mask[i]) r_mem[w_addr][i*8 +: 8] <= br_wr_data[i*8 +: 8];
endmodule
